axi_mem_responder: RTL
======================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameters: AxiIdWidth, default 4, ID width; AxiAddrWidth, default 64, address width; AxiDataWidth, default 64, data width (only 64 supported); MemWords, default 4096, number of 64-bit words in the internal array.
REQ-002 SHALL have ports: clk_i  in  1  sole clock, all logic on its rising edge; rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have AW channel ports: awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid  in  (widths per parameters)  write address; awready  out  1.
REQ-004 SHALL have W channel ports: wdata  in  64; wstrb  in  8; wlast  in  1; wvalid  in  1; wready  out  1.
REQ-005 SHALL have B channel ports: bid  out  AxiIdWidth; bresp  out  2; bvalid  out  1; bready  in  1.
REQ-006 SHALL have AR channel ports: arid/araddr/arlen/arsize/arburst/arvalid  in  read address; arready  out  1.
REQ-007 SHALL have R channel ports: rid  out  AxiIdWidth; rdata  out  64; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1.

Function
REQ-008 SHALL act as the AXI4 slave end of the SoC DRAM port; lock/cache/prot inputs are not ports; every VALID, once high, SHALL be held with stable payload until its READY.
REQ-009 SHALL use one FSM: IDLE, WRITE, WRESP, READ; exactly one burst in flight.
REQ-010 In IDLE, awready and arready SHALL be high; when both awvalid and arvalid are high in the same cycle, SHALL grant the channel not granted last (write first after reset) and drop the other READY that cycle.
REQ-011 AW handshake SHALL latch id/addr/len/size/burst, load beat counter = awlen, go to WRITE.
REQ-012 In WRITE, wready SHALL be high; each W handshake SHALL write the bytes enabled by wstrb at word addr[log2(MemWords)+2:3]; after beat awlen+1, go to WRESP regardless of wlast.
REQ-013 In WRESP, bvalid SHALL be high with latched bid; on bready, return to IDLE; first bvalid SHALL occur the cycle after the last W handshake.
REQ-014 AR handshake SHALL latch fields, go to READ; first rvalid SHALL be 2 cycles after the AR handshake; with rready held high, beats SHALL be one per cycle; rready low SHALL stall without data loss (skid register); rlast SHALL be high on beat arlen+1 only; after its handshake, return to IDLE.
REQ-015 Address update per beat: FIXED unchanged; INCR addr + (1<<size); WRAP increments within a boundary aligned to (len+1)<<size, wrapping to its base; size >3 and WRAP with len not in {1,3,7,15} SHALL be treated as INCR with size 3.
REQ-016 INCR bursts crossing the array end SHALL continue per REQ-019/REQ-020, never corrupting other state.
REQ-017 Read-after-write to the same word across consecutive bursts SHALL return the new data.

Reset
REQ-018 While rst_ni is low: FSM=IDLE, awready=arready=1 after release, wready=bvalid=rvalid=rlast=0, bid/rid/bresp/rresp/rdata=0, arbitration pointer=write; reset mid-burst SHALL abandon the burst; array contents SHALL be undefined.

Configuration
REQ-019 With AXI_RESP_ERR_EN defined: a beat whose word index is >= MemWords SHALL return SLVERR (2'b10), suppress its write, return rdata=0; bresp SHALL be SLVERR if any beat of the burst was out of range.
REQ-020 Without AXI_RESP_ERR_EN: word index SHALL wrap modulo MemWords and all responses SHALL be OKAY (2'b00).

Verification
REQ-021 AW id=3 addr=0x80000000 len=3 INCR size=3, 4 W beats 0x11..0x44 strb=0xFF -> bvalid one cycle after last W, bid=3, bresp=OKAY; AR same -> 4 R beats 0x11..0x44, rlast on 4th, rid=3.
REQ-022 WRAP len=3 size=3 addr=0x18 read after writing words 0..3 = A,B,C,D -> R data D,A,B,C.
REQ-023 awvalid and arvalid both high from IDLE after reset -> write granted first, then read; repeat -> read granted first.
REQ-024 8-beat read with rready toggling 1,0,0,1 pattern -> all 8 beats delivered in order, no duplicates or loss, payload stable while stalled.
REQ-025 With AXI_RESP_ERR_EN, write at word index MemWords -> bresp=SLVERR, memory unchanged; without it, same write lands at word 0, bresp=OKAY.
REQ-026 rst_ni low during beat 2 of a 4-beat write -> wready/bvalid 0 immediately, awready 1 after release, new burst completes normally.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal array of 64-bit words, serving one burst at a time.
// Optional macro AXI_RESP_ERR_EN: out-of-range beats answer SLVERR instead of wrapping.
module axi_mem_responder #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned MemWords     = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [AxiIdWidth-1:0]       awid,
  input  logic [AxiAddrWidth-1:0]     awaddr,
  input  logic [7:0]                  awlen,
  input  logic [2:0]                  awsize,
  input  logic [1:0]                  awburst,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [AxiDataWidth-1:0]     wdata,
  input  logic [AxiDataWidth/8-1:0]   wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [AxiIdWidth-1:0]       bid,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [AxiIdWidth-1:0]       arid,
  input  logic [AxiAddrWidth-1:0]     araddr,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [AxiIdWidth-1:0]       rid,
  output logic [AxiDataWidth-1:0]     rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready
);

  localparam int unsigned IdxWidth  = $clog2(MemWords);
  localparam int unsigned StrbWidth = AxiDataWidth / 8;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_e;

  state_e                  state_q, state_d;
  logic                    prio_rd_q;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic                    rd_done_q;

  logic [AxiDataWidth-1:0] mem [MemWords];

  logic                    contend_c;
  logic                    aw_hs_c;
  logic                    ar_hs_c;
  logic                    w_hs_c;
  logic                    r_hs_c;
  logic                    rd_issue_c;
  logic                    mem_we_c;
  logic                    oor_c;
  logic [IdxWidth-1:0]     idx_c;
  logic [AxiAddrWidth-1:0] addr_next_c;
  logic                    aw_incr_c;
  logic                    ar_incr_c;
  logic                    unused_c;

  // Oversized beats and malformed wraps degrade to a plain 8-byte INCR burst.
  function automatic logic force_incr(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
    return (size > 3'd3) || ((burst == BurstWrap) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
    logic [AxiAddrWidth-1:0] step;
    logic [AxiAddrWidth-1:0] mask;
    logic [AxiAddrWidth-1:0] inc;
    step = AxiAddrWidth'(1) << size;
    mask = ((AxiAddrWidth'(len) + AxiAddrWidth'(1)) << size) - AxiAddrWidth'(1);
    inc  = a + step;
    case (burst)
      BurstFixed: return a;
      BurstWrap:  return (a & ~mask) | (inc & mask);
      default:    return inc;
    endcase
  endfunction

  assign contend_c   = awvalid && arvalid;
  assign aw_hs_c     = awvalid && awready;
  assign ar_hs_c     = arvalid && arready;
  assign w_hs_c      = wvalid && wready;
  assign r_hs_c      = rvalid && rready;
  assign rd_issue_c  = (state_q == S_READ) && !rd_done_q && (!rvalid || rready);
  assign mem_we_c    = w_hs_c && !oor_c;
  assign idx_c       = addr_q[IdxWidth+2:3];
  assign addr_next_c = next_addr(addr_q, len_q, size_q, burst_q);
  assign aw_incr_c   = force_incr(awlen, awsize, awburst);
  assign ar_incr_c   = force_incr(arlen, arsize, arburst);
  assign unused_c    = wlast;

`ifdef AXI_RESP_ERR_EN
  assign oor_c = |addr_q[AxiAddrWidth-1:IdxWidth+3];
`else
  assign oor_c = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake readies; IDLE arbitrates a simultaneous AW/AR.
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        awready = !(contend_c && prio_rd_q);
        arready = !(contend_c && !prio_rd_q);
        if (awvalid && awready)      state_d = S_WRITE;
        else if (arvalid && arready) state_d = S_READ;
      end
      S_WRITE: begin
        wready = 1'b1;
        if (wvalid && (cnt_q == 8'd0)) state_d = S_WRESP;
      end
      S_WRESP: begin
        bvalid = 1'b1;
        if (bready) state_d = S_IDLE;
      end
      S_READ: begin
        if (r_hs_c && rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst context, response fields and the R output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_rd_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      rd_done_q <= 1'b0;
      bid       <= '0;
      bresp     <= RespOkay;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= RespOkay;
      rlast     <= 1'b0;
      rvalid    <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && contend_c) prio_rd_q <= !prio_rd_q;

      if (aw_hs_c) begin
        addr_q  <= awaddr;
        len_q   <= awlen;
        cnt_q   <= awlen;
        size_q  <= aw_incr_c ? 3'd3 : awsize;
        burst_q <= aw_incr_c ? BurstIncr : awburst;
        bid     <= awid;
        err_q   <= 1'b0;
      end else if (ar_hs_c) begin
        addr_q    <= araddr;
        len_q     <= arlen;
        cnt_q     <= arlen;
        size_q    <= ar_incr_c ? 3'd3 : arsize;
        burst_q   <= ar_incr_c ? BurstIncr : arburst;
        rid       <= arid;
        rd_done_q <= 1'b0;
      end else if (w_hs_c) begin
        addr_q <= addr_next_c;
        err_q  <= err_q | oor_c;
        if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        else               bresp <= (err_q || oor_c) ? RespSlvErr : RespOkay;
      end else if (rd_issue_c) begin
        addr_q <= addr_next_c;
        if (cnt_q != 8'd0) cnt_q     <= cnt_q - 8'd1;
        else               rd_done_q <= 1'b1;
      end

      // A beat is fetched only when the output slot is free or draining, so stalls hold data.
      if (rd_issue_c) begin
        rvalid <= 1'b1;
        rlast  <= (cnt_q == 8'd0);
        rresp  <= oor_c ? RespSlvErr : RespOkay;
        rdata  <= oor_c ? '0 : mem[idx_c];
      end else if (r_hs_c) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (wstrb[b]) mem[idx_c][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
